// File: rtl/vc_wrr_arbiter.sv
// Weighted round-robin pop scheduler between the VC0/VC1 FIFOs and the D0/D1
// destination FIFOs. Pops are issued combinationally from the registered FSM
// state. Each popped word is steered to D0 or D1 by its destination bit and
// pushed two cycles after its pop.
module vc_wrr_arbiter #(
  parameter int BW       = 6,
  parameter int DEST_BIT = 4,
  parameter int WW       = 4
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          init,
  input  logic [WW-1:0] weight_vc0,
  input  logic [WW-1:0] weight_vc1,
  input  logic          vc0_empty,
  input  logic          vc1_empty,
  input  logic [BW-1:0] vc0_data,
  input  logic [BW-1:0] vc1_data,
  input  logic          d0_almost_full,
  input  logic          d1_almost_full,
  output logic          vc0_pop,
  output logic          vc1_pop,
  output logic          d0_push,
  output logic          d1_push,
  output logic [BW-1:0] d_data_out,
  output logic          arb_idle,
  output logic          arb_grant
);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_SERVE0,
    ST_SERVE1
  } state_t;

  state_t        state;
  logic [WW-1:0] w0_reg;
  logic [WW-1:0] w1_reg;
  logic [WW-1:0] credit;
  // VC that owned the bus most recently; reset to VC1 so VC0 wins the first tie.
  logic          last_served;

  logic          pop_v1;
  logic          pop_src1;
  logic [BW-1:0] rd_word;

  logic          backpressure;
  logic          serving;
  logic          own_is1;
  logic          own_empty;
  logic          oth_empty;
  logic          own_pop;
  logic          round_done;
  logic [WW-1:0] own_w;
  logic [WW-1:0] oth_w;

  // Owner-relative view of the FIFO flags and weights, plus the pop decision.
  // Both destinations must have room because the target is unknown until read.
  always_comb begin
    backpressure = d0_almost_full | d1_almost_full;
    serving      = (state == ST_SERVE0) || (state == ST_SERVE1);
    own_is1      = (state == ST_SERVE1);
    own_empty    = own_is1 ? vc1_empty : vc0_empty;
    oth_empty    = own_is1 ? vc0_empty : vc1_empty;
    own_w        = own_is1 ? w1_reg : w0_reg;
    oth_w        = own_is1 ? w0_reg : w1_reg;
    own_pop      = serving && !own_empty && !backpressure && !init;
    round_done   = own_empty || (own_pop && (credit == WW'(1)));
  end

  assign vc0_pop   = own_pop && !own_is1;
  assign vc1_pop   = own_pop && own_is1;
  assign arb_idle  = (state == ST_IDLE);
  assign arb_grant = own_is1;
  assign rd_word   = pop_src1 ? vc1_data : vc0_data;

  // Arbitration FSM: weight loading, owner selection and per-round credit.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state       <= ST_INIT;
      w0_reg      <= WW'(1);
      w1_reg      <= WW'(1);
      credit      <= '0;
      last_served <= 1'b1;
    end else if (init) begin
      state <= ST_INIT;
      if (state == ST_INIT) begin
        w0_reg <= (weight_vc0 == '0) ? WW'(1) : weight_vc0;
        w1_reg <= (weight_vc1 == '0) ? WW'(1) : weight_vc1;
      end
    end else begin
      case (state)
        ST_INIT: state <= ST_IDLE;
        ST_IDLE: begin
          if (!vc0_empty && (vc1_empty || last_served)) begin
            state       <= ST_SERVE0;
            credit      <= w0_reg;
            last_served <= 1'b0;
          end else if (!vc1_empty) begin
            state       <= ST_SERVE1;
            credit      <= w1_reg;
            last_served <= 1'b1;
          end
        end
        ST_SERVE0, ST_SERVE1: begin
          // A stall (owner non-empty under backpressure) leaves both
          // state and credit untouched; the reload below overrides the
          // decrement when the round ends on this pop.
          if (own_pop) credit <= credit - WW'(1);
          if (round_done) begin
            if (!oth_empty) begin
              state       <= own_is1 ? ST_SERVE0 : ST_SERVE1;
              credit      <= oth_w;
              last_served <= !own_is1;
            end else if (!own_empty) begin
              credit      <= own_w;
              last_served <= own_is1;
            end else begin
              state  <= ST_IDLE;
              credit <= '0;
            end
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  // Two-stage pop-to-push pipeline: remember the source of a pop, then
  // capture the read data and steer it by its destination bit.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      pop_v1     <= 1'b0;
      pop_src1   <= 1'b0;
      d_data_out <= '0;
      d0_push    <= 1'b0;
      d1_push    <= 1'b0;
    end else begin
      pop_v1   <= vc0_pop | vc1_pop;
      pop_src1 <= vc1_pop;
      d0_push  <= pop_v1 && !rd_word[DEST_BIT];
      d1_push  <= pop_v1 && rd_word[DEST_BIT];
      if (pop_v1) d_data_out <= rd_word;
    end
  end

endmodule

// File: doc/vc_wrr_arbiter.md
Name: vc_wrr_arbiter

Overview:
- Weighted round-robin scheduler between the VC0 and VC1 16-deep FIFOs and the D0/D1 4-deep destination FIFOs.
- Decides each cycle which VC FIFO to pop and steers the popped word to D0 or D1 using its destination bit.
- Honours almost-full backpressure from both destination FIFOs.
- Sits in the interconnect between the VC stage and the D stage, replacing fixed-priority pop logic; weights come from the conditions state machine at init.

Parameters:
- BW, 6, word width.
- DEST_BIT, 4, bit index of destination within the word (0 selects D0, 1 selects D1).
- WW, 4, weight width.

Ports:
- clk  in  1  clock.
- reset_L  in  1  asynchronous active-low reset.
- init  in  1  load weights while high.
- weight_vc0  in  WW  pops granted to VC0 per round.
- weight_vc1  in  WW  pops granted to VC1 per round.
- vc0_empty  in  1  VC0 FIFO empty.
- vc1_empty  in  1  VC1 FIFO empty.
- vc0_data  in  BW  VC0 read data, valid the cycle after vc0_pop.
- vc1_data  in  BW  VC1 read data, valid the cycle after vc1_pop.
- d0_almost_full  in  1  D0 above its HIGH threshold.
- d1_almost_full  in  1  D1 above its HIGH threshold.
- vc0_pop  out  1  pop VC0.
- vc1_pop  out  1  pop VC1.
- d0_push  out  1  push to D0.
- d1_push  out  1  push to D1.
- d_data_out  out  BW  word for D0/D1.
- arb_idle  out  1  FSM in IDLE.
- arb_grant  out  1  current owner (0 is VC0, 1 is VC1).

Behaviour:
- Reset (asynchronous, reset_L low): FSM goes to INIT.
  - Outputs clear: all pops, pushes and d_data_out are 0; arb_idle=0; arb_grant=0.
  - w0_reg and w1_reg are 1; credit is 0; pipeline valid bits are 0.
  - Any in-flight word is discarded.
- States:
  - INIT: while init=1, latch weights each cycle. A weight of 0 is stored as 1. Leave to IDLE when init=0.
  - IDLE: arb_idle=1. Go to SERVE0 if VC0 is non-empty; otherwise go to SERVE1 if VC1 is non-empty. When both are non-empty, start with the VC that was not served last (reset value: VC0). Load credit with that VC's weight.
  - SERVE0 / SERVE1: arb_grant=0 or 1 respectively.
- Pop enable in a SERVE state: own FIFO non-empty AND d0_almost_full=0 AND d1_almost_full=0. The destination is unknown before the read, so both must be clear.
- Each pop decrements credit.
- Switch rule: at the edge where credit reaches 0, or the owner's FIFO is empty:
  - If the other VC is non-empty, go to its SERVE state and reload credit with its weight.
  - Otherwise, if the owner is still non-empty, stay and reload credit.
  - Otherwise go to IDLE.
- A backpressure stall (almost_full) keeps the state and credit unchanged.
- Pipeline, latency pop-to-push = 2 cycles:
  - Cycle N: pop.
  - Cycle N+1: FIFO data is present; it is registered together with its source.
  - Cycle N+2: d_data_out holds the word; exactly one of d0_push/d1_push is high, chosen by d_data_out[DEST_BIT], for one cycle.
- Back-to-back pops produce back-to-back pushes, so throughput is 1 word per cycle.
- Up to 2 words are in flight when almost_full rises. D HIGH thresholds must be ≤ depth−2; the arbiter does not re-check after a pop has issued.
- Never pop a FIFO whose empty flag is 1 in the same cycle. vc0_pop and vc1_pop are mutually exclusive.
- init=1 in any state returns the FSM to INIT. Pops stop in that cycle; words already in flight still complete their push.
- d_data_out holds its last value when no push is active.

Test Plan:
- Reset mid-stream: with words in flight, pulse reset_L low between edges -> all outputs 0 immediately; no push follows; FSM in INIT.
- Weights 3/1, both VCs loaded with 8 words, no backpressure -> pop order is VC0×3, VC1×1, repeating; pushes follow each pop exactly 2 cycles later; 16 pushes total.
- Weight 0 for VC0, 1 for VC1, both loaded -> strict alternation VC0, VC1 (zero treated as 1).
- d1_almost_full asserted for 5 cycles mid-run -> no pops during those 5 cycles; state and credit are unchanged; at most 2 pushes complete after assertion; no data is lost and order is preserved.
- Only VC1 has data (3 words: dest 0, 1, 0) -> VC1 is popped 3 times; pushes go to d0_push, then d1_push, then d0_push carrying the exact words; after the last pop FSM returns to IDLE with arb_idle=1.
- VC0 has 1 word, weight_vc0=4, VC1 empty -> single pop, credit abandoned, FSM returns to IDLE; vc0_pop is never high while vc0_empty=1.
